// File: rtl/paddle_ctrl.sv
// paddle_ctrl -- one Pong paddle: manual play, AI tracking and AI return-to-centre.
// It produces the paddle top-left coordinate on a divided movement tick.
//
// Optional feature macro: PADDLE_ACCEL_EN
//   Defined   : a held manual direction boosts the step to 2*STEP after ACCEL_TICKS ticks.
//   Undefined : the step is always STEP and no hold counter exists.
//
// Ports:
//   vga_clk    in   clock
//   sys_rst    in   synchronous active-high reset
//   key[1:0]   in   active-low buttons, [0]=down, [1]=up
//   s          in   speed select (1 = SPEED_FAST period)
//   guiwei     in   round restart, level-sensitive
//   ai_switch  in   1 = AI drives the paddle
//   ball_x/y   in   ball top-left coordinate
//   body_x/y   out  paddle top-left coordinate
//   mode       out  registered mode (0 MANUAL, 1 AI_TRACK, 2 AI_RETURN)
//   moving     out  high for one cycle after a tick that changed body_y
//
// state     | meaning
// MANUAL    | keys move the paddle
// AI_TRACK  | ball in own half, paddle centre follows ball centre
// AI_RETURN | ball away, paddle drifts back to Y_INIT
module paddle_ctrl #(
  parameter int COORD_W     = 10,
  parameter int SIDE        = 0,
  parameter int X_INIT      = 55,
  parameter int Y_INIT      = 200,
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int SLDE_W      = 10,
  parameter int PAD_LEN     = 80,
  parameter int BALL_W      = 16,
  parameter int STEP        = 2,
  parameter int SPEED_FAST  = 80000,
  parameter int SPEED_SLOW  = 190000,
  parameter int DEADZONE    = 0,
  parameter int ACCEL_TICKS = 16
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic [1:0]         key,
  input  logic               s,
  input  logic               guiwei,
  input  logic               ai_switch,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] body_x,
  output logic [COORD_W-1:0] body_y,
  output logic [1:0]         mode,
  output logic               moving
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] Y_MIN_W   = CW1'(SLDE_W);
  localparam logic [CW1-1:0] Y_MAX_W   = CW1'(V_DISP - SLDE_W - PAD_LEN);
  localparam logic [CW1-1:0] Y_INIT_W  = CW1'(Y_INIT);
  localparam logic [CW1-1:0] HALF_PAD  = CW1'(PAD_LEN / 2);
  localparam logic [CW1-1:0] HALF_BALL = CW1'(BALL_W / 2);
  localparam logic [CW1-1:0] DZ        = CW1'(DEADZONE);
  localparam logic [CW1-1:0] OWN_L     = CW1'(H_DISP / 2 - BALL_W);
  localparam logic [CW1-1:0] OWN_R     = CW1'(H_DISP / 2);
  localparam logic [CW1-1:0] STEP_W    = CW1'(STEP);
  localparam logic [21:0]    PER_F_M1  = 22'(SPEED_FAST - 1);
  localparam logic [21:0]    PER_S_M1  = 22'(SPEED_SLOW - 1);

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AI_TRACK  = 2'd1,
    AI_RETURN = 2'd2
  } mode_t;

  mode_t          state, state_nxt;
  logic [21:0]    div_cnt;
  logic           tick;
  logic           own_half;
  logic           man_move, man_up;
  logic [CW1-1:0] step_w;
  logic [CW1-1:0] y_w, pc, bc, y_up, y_dn, diff, y_nxt;

  assign body_x = COORD_W'(X_INIT);
  assign mode   = state;

  // An over-range count after an s change ticks at once thanks to >=.
  assign tick = s ? (div_cnt >= PER_F_M1) : (div_cnt >= PER_S_M1);

  assign own_half = (SIDE == 0) ? ({1'b0, ball_x} < OWN_L) : ({1'b0, ball_x} >= OWN_R);

  always_comb begin
    state_nxt = MANUAL;
    if (ai_switch) state_nxt = own_half ? AI_TRACK : AI_RETURN;
  end

  assign man_move = (state_nxt == MANUAL) && ((key == 2'b10) || (key == 2'b01));
  assign man_up   = (key == 2'b01);

`ifdef PADDLE_ACCEL_EN
  localparam int HC_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(ACCEL_TICKS);

  logic [HC_W-1:0] hold_cnt, hold_inc;
  logic            last_up, last_vld;

  // The count this tick would reach decides the step, so the boost starts
  // on the ACCEL_TICKS-th consecutive same-direction repeat.
  always_comb begin
    hold_inc = '0;
    if (last_vld && (last_up == man_up))
      hold_inc = (hold_cnt == HC_MAX) ? hold_cnt : hold_cnt + 1'b1;
    step_w = (man_move && (hold_inc >= HC_MAX)) ? (STEP_W << 1) : STEP_W;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst || guiwei || !man_move) begin
      hold_cnt <= '0;
      last_vld <= 1'b0;
      last_up  <= 1'b0;
    end else if (tick) begin
      hold_cnt <= hold_inc;
      last_vld <= 1'b1;
      last_up  <= man_up;
    end
  end
`else
  localparam int unused_accel_ticks = ACCEL_TICKS;
  assign step_w = STEP_W;
`endif

  always_comb begin
    y_w   = {1'b0, body_y};
    pc    = y_w + HALF_PAD;
    bc    = {1'b0, ball_y} + HALF_BALL;
    y_up  = (y_w >= Y_MIN_W + step_w) ? (y_w - step_w) : Y_MIN_W;
    y_dn  = (y_w + step_w <= Y_MAX_W) ? (y_w + step_w) : Y_MAX_W;
    diff  = (y_w > Y_INIT_W) ? (y_w - Y_INIT_W) : (Y_INIT_W - y_w);
    y_nxt = y_w;
    case (state_nxt)
      MANUAL: begin
        if (key == 2'b10)      y_nxt = y_dn;
        else if (key == 2'b01) y_nxt = y_up;
      end
      AI_TRACK: begin
        if (bc + DZ < pc)      y_nxt = y_up;
        else if (bc > pc + DZ) y_nxt = y_dn;
      end
      default: begin
        if (diff <= step_w)    y_nxt = Y_INIT_W;
        else if (y_w > Y_INIT_W) y_nxt = y_up;
        else                   y_nxt = y_dn;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state   <= MANUAL;
      body_y  <= COORD_W'(Y_INIT);
      div_cnt <= '0;
      moving  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (guiwei) begin
        body_y  <= COORD_W'(Y_INIT);
        div_cnt <= '0;
        moving  <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        body_y  <= y_nxt[COORD_W-1:0];
        moving  <= (y_nxt != y_w);
      end else begin
        div_cnt <= div_cnt + 1'b1;
        moving  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl -- directed bench for paddle_ctrl.
// A left instance (SIDE=0, DEADZONE=4) is fully checked; a right instance
// (SIDE=1) shares the inputs and is checked for its own-half mode decision.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst, s, guiwei, ai;
  logic [1:0] key;
  logic [9:0] bx, by;
  logic [9:0] l_x, l_y, r_x, r_y;
  logic [1:0] l_mode, r_mode;
  logic       l_mov, r_mov;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .SIDE(0), .SPEED_FAST(4), .SPEED_SLOW(8), .DEADZONE(4), .ACCEL_TICKS(3)
  ) u_left (
    .vga_clk(clk), .sys_rst(rst), .key(key), .s(s), .guiwei(guiwei),
    .ai_switch(ai), .ball_x(bx), .ball_y(by),
    .body_x(l_x), .body_y(l_y), .mode(l_mode), .moving(l_mov)
  );

  paddle_ctrl #(
    .SIDE(1), .X_INIT(569), .SPEED_FAST(4), .SPEED_SLOW(8)
  ) u_right (
    .vga_clk(clk), .sys_rst(rst), .key(key), .s(s), .guiwei(guiwei),
    .ai_switch(ai), .ball_x(bx), .ball_y(by),
    .body_x(r_x), .body_y(r_y), .mode(r_mode), .moving(r_mov)
  );

  typedef struct {
    logic [1:0] key;
    logic       ai;
    logic [9:0] bx;
    logic [9:0] by;
    int         ncyc;
    int         ey;
    int         em;
    int         emv;
    int         erm;
  } vec_t;

  vec_t vecs[11];

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // key ai  bx   by  ncyc  y   mode mov rmode
    vecs[0]  = '{2'b10, 1'b0, 10'd400, 10'd0,  3, 200, 0, 0, 0};
    vecs[1]  = '{2'b10, 1'b0, 10'd400, 10'd0,  1, 202, 0, 1, 0};
    vecs[2]  = '{2'b10, 1'b0, 10'd400, 10'd0,  4, 204, 0, 1, 0};
    vecs[3]  = '{2'b11, 1'b0, 10'd400, 10'd0,  4, 204, 0, 0, 0};
    vecs[4]  = '{2'b00, 1'b0, 10'd400, 10'd0,  4, 204, 0, 0, 0};
    vecs[5]  = '{2'b01, 1'b0, 10'd400, 10'd0,  4, 202, 0, 1, 0};
    vecs[6]  = '{2'b01, 1'b0, 10'd400, 10'd0,  2, 202, 0, 0, 0};
    vecs[7]  = '{2'b01, 1'b0, 10'd400, 10'd0,  2, 200, 0, 1, 0};
    vecs[8]  = '{2'b11, 1'b1, 10'd400, 10'd0,  4, 200, 2, 0, 1};
    vecs[9]  = '{2'b11, 1'b1, 10'd100, 10'd50, 4, 198, 1, 1, 2};
    vecs[10] = '{2'b11, 1'b1, 10'd100, 10'd50, 4, 196, 1, 1, 2};

    rst = 1'b1; key = 2'b11; s = 1'b1; guiwei = 1'b0; ai = 1'b0;
    bx = 10'd400; by = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset body_x", l_x, 55);
    chk("reset body_y", l_y, 200);
    chk("reset mode", l_mode, 0);
    chk("reset moving", l_mov, 0);
    chk("reset right body_x", r_x, 569);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      key = vecs[i].key; ai = vecs[i].ai; bx = vecs[i].bx; by = vecs[i].by;
      clocks(vecs[i].ncyc);
      chk($sformatf("vec%0d body_y", i), l_y, vecs[i].ey);
      chk($sformatf("vec%0d mode", i), l_mode, vecs[i].em);
      chk($sformatf("vec%0d moving", i), l_mov, vecs[i].emv);
      chk($sformatf("vec%0d right mode", i), r_mode, vecs[i].erm);
    end

    // AI track upward until the dead-zone band holds it at 22.
    for (int k = 1; k <= 87; k++) begin
      clocks(4);
      chk($sformatf("track up %0d", k), l_y, 196 - 2 * k);
    end
    clocks(4);
    chk("track hold y", l_y, 22);
    chk("track hold moving", l_mov, 0);
    clocks(4);
    chk("track hold y2", l_y, 22);

    // Ball moves low: paddle follows downward.
    by = 10'd300;
    for (int k = 1; k <= 39; k++) begin
      clocks(4);
      chk($sformatf("track down %0d", k), l_y, 22 + 2 * k);
    end

    // Ball leaves own half: mode lags one clock, then return to centre.
    bx = 10'd400;
    #1;
    chk("mode lag", l_mode, 1);
    clocks(1);
    chk("return mode", l_mode, 2);
    chk("return right mode", r_mode, 1);
    clocks(3);
    chk("return first", l_y, 102);
    chk("return moving", l_mov, 1);
    for (int k = 2; k <= 50; k++) begin
      clocks(4);
      chk($sformatf("return %0d", k), l_y, 100 + 2 * k);
    end
    clocks(4);
    chk("return hold y", l_y, 200);
    chk("return hold moving", l_mov, 0);

    // Manual down to 300, restart mid-count.
    ai = 1'b0; key = 2'b10;
    for (int k = 1; k <= 50; k++) begin
      clocks(4);
      chk($sformatf("manual down %0d", k), l_y, 200 + 2 * k);
    end
    clocks(2);
    guiwei = 1'b1;
    clocks(1);
    chk("restart y", l_y, 200);
    chk("restart moving", l_mov, 0);
    guiwei = 1'b0;
    clocks(3);
    chk("restart divider cleared", l_y, 200);
    clocks(1);
    chk("restart first tick", l_y, 202);
    for (int k = 2; k <= 95; k++) begin
      clocks(4);
      chk($sformatf("to bottom %0d", k), l_y, 200 + 2 * k);
    end
    clocks(4);
    chk("bottom saturate y", l_y, 390);
    chk("bottom saturate moving", l_mov, 0);

    // Slow speed, then switch to fast at div_cnt=6: immediate tick.
    s = 1'b0; key = 2'b01;
    clocks(6);
    chk("slow no tick", l_y, 390);
    s = 1'b1;
    clocks(1);
    chk("speed switch tick", l_y, 388);
    chk("speed switch moving", l_mov, 1);

    // Restart held: position pinned, mode keeps following inputs.
    guiwei = 1'b1; ai = 1'b1; bx = 10'd100; by = 10'd50;
    clocks(2);
    chk("held restart y", l_y, 200);
    chk("held restart mode", l_mode, 1);
    chk("held restart right mode", r_mode, 2);
    chk("held restart moving", l_mov, 0);

`ifdef PADDLE_ACCEL_EN
    ai = 1'b0; key = 2'b01;
    clocks(1);
    guiwei = 1'b0;
    begin
      int exp_acc[5] = '{198, 196, 194, 190, 186};
      for (int k = 0; k < 5; k++) begin
        clocks(4);
        chk($sformatf("accel %0d", k), l_y, exp_acc[k]);
      end
    end
    key = 2'b11;
    clocks(4);
    chk("accel release hold", l_y, 186);
    key = 2'b01;
    clocks(4);
    chk("accel after release", l_y, 184);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle controller for the Pong datapath: one instance per side, producing the paddle's top-left coordinate for the VGA renderer and collision logic. It generalises the fixed left-hand paddle with configurable geometry, step, speed, side and AI dead-zone. A three-state mode machine covers manual play, AI tracking and AI return-to-centre. Updates occur on a divided movement tick derived from `vga_clk`.

## Interface
Parameters:
- `COORD_W`, 10: coordinate width.
- `SIDE`, 0: court side; 0 = left, 1 = right. Sets the AI "own half" test.
- `X_INIT`, 55: constant `body_x`.
- `Y_INIT`, 200: reset / round-restart `body_y`.
- `H_DISP`, 640: display width.
- `V_DISP`, 480: display height.
- `SLDE_W`, 10: wall thickness.
- `PAD_LEN`, 80: paddle height; must be even.
- `BALL_W`, 16: ball size; must be even.
- `STEP`, 2: pixels moved per tick.
- `SPEED_FAST`, 80000: tick period in clocks when `s=1`.
- `SPEED_SLOW`, 190000: tick period in clocks when `s=0`.
- `DEADZONE`, 0: AI hold band, in pixels.
- `ACCEL_TICKS`, 16: manual hold ticks before boost; only used with `PADDLE_ACCEL_EN`.

Ports:
- `vga_clk`, in, 1: the only clock.
- `sys_rst`, in, 1: reset; synchronous, active-high.
- `key`, in, 2: active-low buttons; `key[0]`=down, `key[1]`=up.
- `s`, in, 1: speed select.
- `guiwei`, in, 1: round restart, level-sensitive.
- `ai_switch`, in, 1: 1 = AI drives the paddle.
- `ball_x`, in, `COORD_W`: ball top-left x.
- `ball_y`, in, `COORD_W`: ball top-left y.
- `body_x`, out, `COORD_W`: paddle x.
- `body_y`, out, `COORD_W`: paddle y.
- `mode`, out, 2: registered state. 0 = MANUAL, 1 = AI_TRACK, 2 = AI_RETURN.
- `moving`, out, 1: high for the one cycle after a tick that changed `body_y`.

## Operation
- Bounds: `Y_MIN = SLDE_W`; `Y_MAX = V_DISP - SLDE_W - PAD_LEN`.
- Every move saturates exactly at a bound: up gives `max(body_y - step, Y_MIN)`, down gives `min(body_y + step, Y_MAX)`.
- Own-half test:
  - `SIDE=0`: `ball_x < H_DISP/2 - BALL_W`.
  - `SIDE=1`: `ball_x >= H_DISP/2`.
- Next state, evaluated every clock from current inputs:
  - `!ai_switch` → MANUAL.
  - `ai_switch` and ball in own half → AI_TRACK.
  - otherwise → AI_RETURN.
  - The tick decision uses this next state, not the registered `mode`.
- MANUAL:
  - `key==2'b10` moves down.
  - `key==2'b01` moves up.
  - `2'b00` or `2'b11` holds.
- AI_TRACK:
  - Centres: `pc = body_y + PAD_LEN/2`, `bc = ball_y + BALL_W/2`, both computed from current values (no stale registered centres).
  - Compare at `COORD_W+1` bits.
  - `bc + DEADZONE < pc` moves up; `bc > pc + DEADZONE` moves down; otherwise holds.
- AI_RETURN:
  - `|body_y - Y_INIT| <= step` loads `Y_INIT`.
  - Otherwise move `step` toward `Y_INIT`.
- `step = STEP`, except in the manual boost case (see Configuration).
- `body_x` is constant at `X_INIT`.

## Timing
- Divider: `div_cnt`, 22 bits, counts up each clock.
  - `tick = (div_cnt >= period-1)`, where `period` is selected by `s`.
  - On tick, `div_cnt` returns to 0.
  - Changing `s` mid-count is safe: an over-range count ticks immediately.
- Priority: `sys_rst` > `guiwei` > `tick`.
- Reset values: `body_x=X_INIT`, `body_y=Y_INIT`, `mode=0`, `moving=0`, `div_cnt=0`, hold counter 0.
- `guiwei` held high:
  - `body_y=Y_INIT`, `div_cnt=0`, hold counter 0, `moving=0`.
  - `mode` keeps updating.
- Latency: `body_y` changes in the cycle after the tick. `mode` lags its inputs by one clock.
- Tick at a bound with motion toward that bound: `body_y` unchanged, `moving=0`.

## Configuration
- `PADDLE_ACCEL_EN` defined:
  - In MANUAL, a saturating hold counter increments on each tick that moves in the same direction as the previous tick.
  - It clears on release, on direction reversal, on leaving MANUAL, and on `guiwei`.
  - Once the counter reaches `ACCEL_TICKS`, `step = 2*STEP`.
  - AI states always use `STEP`.
- `PADDLE_ACCEL_EN` undefined: no hold counter is instantiated, and `step = STEP` always.

## Test plan
Common overrides: `SPEED_FAST=4`, `SPEED_SLOW=8`.
- Reset: `sys_rst=1` for 3 clocks → `body_x=55`, `body_y=200`, `mode=0`, `moving=0`. First tick after release is at clock 4 with `s=1`.
- Manual down, `key=2'b10` held → `body_y` steps 202, 204, …, saturates at 390 with `moving=0` there. `key=2'b11` → holds.
- AI track, `SIDE=0`, `ai_switch=1`, `ball_x=100`, `ball_y=50`, `DEADZONE=4` → `mode=1`, `body_y` falls by 2 per tick to 22 (`pc=62`) and holds. Set `ball_y=300` → rises.
- AI return: `ball_x=400`, `body_y=100` → `mode=2`, steps 102, … to 200, then holds. `SIDE=1` with the same ball → `mode=1`.
- Restart and speed switch: `guiwei` pulsed at `body_y=300` → next clock `body_y=200`, `div_cnt=0`. Switch `s` from 0 to 1 at `div_cnt=6` → tick on the next clock.
- With `PADDLE_ACCEL_EN` and `ACCEL_TICKS=3`, `key=2'b01` held from 200 → 198, 196, 194, 190, 186. Release → next move is −2.
